spi_mem_controller: RTL and testbench

//   SPI master that serves the CPU core's instruction fetches, loads and stores.
//   It sits directly downstream of the CPU. It accepts one request at a time
//   (address, byte count, read/write) and runs a serial READ (0x03) or WRITE (0x02)

---
 rtl/spi_mem_if.sv | 29 ++
 rtl/spi_mem_controller.sv | 180 ++++++++++++++++++
 tb/tb_spi_mem_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_if.sv
// Request/response and SPI pin bundle between the CPU side and the SPI memory controller.
interface spi_mem_if #(
  parameter int address_size = 18
);
  logic                    start_request;
  logic                    is_write;
  logic [address_size-1:0] target_address;
  logic [2:0]              num_bytes;
  logic [31:0]             write_value;
  logic [31:0]             fetched_value;
  logic                    request_done;
  logic                    sclk;
  logic                    mosi;
  logic                    cs1;
  logic                    cs2;
  logic                    miso;

  // Requester plus memory-device side: issues requests and supplies miso.
  modport master (
    output start_request, is_write, target_address, num_bytes, write_value, miso,
    input  fetched_value, request_done, sclk, mosi, cs1, cs2
  );

  // Controller side: serves requests and drives the SPI pins.
  modport slave (
    input  start_request, is_write, target_address, num_bytes, write_value, miso,
    output fetched_value, request_done, sclk, mosi, cs1, cs2
  );
endinterface

// File: rtl/spi_mem_controller.sv
// SPI mode-0 master serving single CPU memory requests. It issues READ (0x03) or
// WRITE (0x02), a 24-bit address and 1..4 data bytes to flash (cs1) or RAM (cs2).
module spi_mem_controller #(
  parameter int address_size = 18
) (
  input logic     clk,
  input logic     rst,
  spi_mem_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STOP, DONE} state_t;

  state_t      state_reg, state_next;
  logic        phase_reg, phase_next;        // 0 = sclk low half, 1 = sclk high half
  logic [5:0]  bit_cnt_reg, bit_cnt_next;    // bit index within the current field
  logic [63:0] tx_reg, tx_next;              // outgoing bits, current bit at [63]
  logic        wr_reg, wr_next;
  logic [2:0]  n_reg, n_next;
  logic        sclk_reg, sclk_next;
  logic        mosi_reg, mosi_next;
  logic        cs1_reg, cs1_next;
  logic        cs2_reg, cs2_next;
  logic        done_reg, done_next;
  logic [31:0] fetched_reg, fetched_next;

  logic [2:0]  n_in;
  logic [23:0] addr24;
  logic [31:0] data_stream;
  logic [63:0] tx_load;
  logic [5:0]  last_bit;
  logic        sel_ram;

  assign bus.sclk          = sclk_reg;
  assign bus.mosi          = mosi_reg;
  assign bus.cs1           = cs1_reg;
  assign bus.cs2           = cs2_reg;
  assign bus.request_done  = done_reg;
  assign bus.fetched_value = fetched_reg;

  // Request decoding: clamp byte count, split chip select from address, order store bytes.
  always_comb begin
    n_in    = (bus.num_bytes > 3'd4) ? 3'd4 : bus.num_bytes;
    sel_ram = bus.target_address[address_size-1];
    addr24  = 24'(bus.target_address[address_size-2:0]);
    data_stream = 32'h0;
    for (int i = 0; i < 4; i++) begin
      data_stream[31-8*i -: 8] = bus.write_value[8*i +: 8];
    end
    tx_load = {(bus.is_write ? 8'h02 : 8'h03), addr24,
               (bus.is_write ? data_stream : 32'h0)};
  end

  // Index of the final bit in the field being shifted.
  always_comb begin
    last_bit = 6'd0;
    case (state_reg)
      CMD:     last_bit = 6'd7;
      ADDR:    last_bit = 6'd23;
      DATA:    last_bit = {n_reg, 3'b000} - 6'd1;
      default: last_bit = 6'd0;
    endcase
  end

  // Next-state and registered-output logic for the transaction sequencer.
  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    bit_cnt_next = bit_cnt_reg;
    tx_next      = tx_reg;
    wr_next      = wr_reg;
    n_next       = n_reg;
    sclk_next    = sclk_reg;
    mosi_next    = mosi_reg;
    cs1_next     = cs1_reg;
    cs2_next     = cs2_reg;
    done_next    = done_reg;
    fetched_next = fetched_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start_request && !done_reg) begin
          wr_next      = bus.is_write;
          n_next       = n_in;
          fetched_next = 32'h0;
          if (n_in == 3'd0) begin
            // Nothing to move: complete without touching the bus.
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next   = CMD;
            phase_next   = 1'b0;
            bit_cnt_next = 6'd0;
            tx_next      = tx_load;
            mosi_next    = tx_load[63];
            sclk_next    = 1'b0;
            cs1_next     = sel_ram;
            cs2_next     = ~sel_ram;
          end
        end
      end

      CMD, ADDR, DATA: begin
        if (!phase_reg) begin
          sclk_next  = 1'b1;
          phase_next = 1'b1;
        end else begin
          // End of the high half: slave data is valid, advance to the next bit.
          sclk_next  = 1'b0;
          phase_next = 1'b0;
          tx_next    = {tx_reg[62:0], 1'b0};
          mosi_next  = tx_reg[62];
          if (state_reg == DATA && !wr_reg) begin
            fetched_next = {fetched_reg[30:0], bus.miso};
          end
          if (bit_cnt_reg == last_bit) begin
            bit_cnt_next = 6'd0;
            case (state_reg)
              CMD:  state_next = ADDR;
              ADDR: state_next = DATA;
              default: begin
                state_next = STOP;
                cs1_next   = 1'b1;
                cs2_next   = 1'b1;
                mosi_next  = 1'b0;
              end
            endcase
          end else begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end
        end
      end

      STOP: begin
        state_next = DONE;
        done_next  = 1'b1;
      end

      DONE: begin
        if (!bus.start_request) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      phase_reg   <= 1'b0;
      bit_cnt_reg <= 6'd0;
      tx_reg      <= 64'h0;
      wr_reg      <= 1'b0;
      n_reg       <= 3'd0;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      cs1_reg     <= 1'b1;
      cs2_reg     <= 1'b1;
      done_reg    <= 1'b0;
      fetched_reg <= 32'h0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
      wr_reg      <= wr_next;
      n_reg       <= n_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      cs1_reg     <= cs1_next;
      cs2_reg     <= cs2_next;
      done_reg    <= done_next;
      fetched_reg <= fetched_next;
    end
  end

endmodule

// File: tb/tb_spi_mem_controller.sv
// Directed bench for spi_mem_controller: a transaction-level model tracks each
// accepted request and checks the SPI pins and handshake every cycle.
module tb_spi_mem_controller;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  spi_mem_if #(.address_size(18)) bus ();

  spi_mem_controller #(.address_size(18)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bytes the simulated memory returns, first byte in [31:24].
  logic [31:0] miso_word;

  // Model state.
  localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;
  int          mode;
  int          k;
  int          done_k;
  int          m_n;
  logic        m_ram;
  logic [63:0] m_stream;
  logic [31:0] m_fetch;
  logic        fresh_reset;

  initial begin
    mode = M_IDLE;
    k = 0;
    done_k = 0;
    m_n = 0;
    m_ram = 1'b0;
    m_stream = 64'h0;
    m_fetch = 32'h0;
    fresh_reset = 1'b1;
    bus.miso = 1'b1;
  end

  // Model plus memory emulation: expectations follow from the accepted request
  // (command byte, 24-bit address, n data bytes, two clocks per bit).
  always @(negedge clk) begin
    if (mode == M_IDLE) begin
      bus.miso = 1'b1;
      if (!rst) begin
        check("idle_cs1", 32'(bus.cs1), 32'd1);
        check("idle_cs2", 32'(bus.cs2), 32'd1);
        check("idle_sclk", 32'(bus.sclk), 32'd0);
        check("idle_done", 32'(bus.request_done), 32'd0);
        if (fresh_reset) check("reset_fetched", bus.fetched_value, 32'h0);
        if (bus.start_request) begin
          m_n   = (bus.num_bytes > 3'd4) ? 4 : int'(bus.num_bytes);
          m_ram = bus.target_address[17];
          m_stream = {(bus.is_write ? 8'h02 : 8'h03), 7'b0, bus.target_address[16:0], 32'h0};
          m_fetch = 32'h0;
          for (int j = 0; j < m_n; j++) begin
            if (bus.is_write) m_stream[31-8*j -: 8] = bus.write_value[8*j +: 8];
            else m_fetch = (m_fetch << 8) | 32'(miso_word[31-8*j -: 8]);
          end
          done_k = (m_n == 0) ? 1 : 2 * (32 + 8 * m_n) + 2;
          k = 0;
          mode = M_BUSY;
          fresh_reset = 1'b0;
        end
      end
    end else if (mode == M_BUSY) begin
      k++;
      if (k == done_k) begin
        check("done_rise", 32'(bus.request_done), 32'd1);
        check("done_fetched", bus.fetched_value, m_fetch);
        check("done_cs", {30'b0, bus.cs1, bus.cs2}, 32'd3);
        check("done_sclk", 32'(bus.sclk), 32'd0);
        mode = bus.start_request ? M_DONE : M_IDLE;
      end else if (k == done_k - 1) begin
        check("end_cs", {30'b0, bus.cs1, bus.cs2}, 32'd3);
        check("end_sclk", 32'(bus.sclk), 32'd0);
        check("end_done", 32'(bus.request_done), 32'd0);
      end else begin
        check("busy_cs1", 32'(bus.cs1), m_ram ? 32'd1 : 32'd0);
        check("busy_cs2", 32'(bus.cs2), m_ram ? 32'd0 : 32'd1);
        check("busy_sclk", 32'(bus.sclk), (k % 2 == 0) ? 32'd1 : 32'd0);
        check("busy_mosi", 32'(bus.mosi), 32'(m_stream[63 - (k - 1) / 2]));
        check("busy_done", 32'(bus.request_done), 32'd0);
        if (k % 2 == 1) begin
          if ((k - 1) / 2 >= 32) bus.miso = miso_word[31 - ((k - 1) / 2 - 32)];
          else bus.miso = 1'b1;
        end
      end
    end else begin
      check("hold_done", 32'(bus.request_done), 32'd1);
      check("hold_fetched", bus.fetched_value, m_fetch);
      check("hold_cs", {30'b0, bus.cs1, bus.cs2}, 32'd3);
      check("hold_sclk", 32'(bus.sclk), 32'd0);
      if (!bus.start_request) mode = M_IDLE;
    end
    if (rst) begin
      mode = M_IDLE;
      fresh_reset = 1'b1;
    end
  end

  int txn;

  // One request; called at posedge+1. Literal latency and result pin the model.
  task automatic run_req(input logic wr, input logic [17:0] addr, input logic [2:0] nb,
                         input logic [31:0] wv, input logic [31:0] mbytes, input int hold,
                         input int drop_after, input int exp_lat, input logic [31:0] exp_fetch);
    int  lat;
    bit  got;
    miso_word          = mbytes;
    bus.is_write       = wr;
    bus.target_address = addr;
    bus.num_bytes      = nb;
    bus.write_value    = wv;
    bus.start_request  = 1'b1;
    lat = 0;
    got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (drop_after > 0 && lat == drop_after) bus.start_request = 1'b0;
      if (bus.request_done) got = 1;
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("fetched", bus.fetched_value, exp_fetch);
    end
    if (bus.start_request) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check("done_held", 32'(bus.request_done), 32'd1);
      end
    end
    bus.start_request = 1'b0;
    @(posedge clk);
    #1;
    check("done_fall", 32'(bus.request_done), 32'd0);
    txn++;
    $display("txn %0d: wr=%0d addr=%05h n=%0d latency=%0d fetched=%08h", txn, wr, addr, nb,
             lat, exp_fetch);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    txn = 0;
    rst = 1'b1;
    miso_word = 32'h0;
    bus.start_request  = 1'b0;
    bus.is_write       = 1'b0;
    bus.target_address = 18'h0;
    bus.num_bytes      = 3'd0;
    bus.write_value    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs1", 32'(bus.cs1), 32'd1);
    check("rst_cs2", 32'(bus.cs2), 32'd1);
    check("rst_done", 32'(bus.request_done), 32'd0);
    check("rst_fetched", bus.fetched_value, 32'h0);
    rst = 1'b0;

    // Flash read of 4 bytes.
    run_req(1'b0, 18'h00100, 3'd4, 32'h0, 32'h13050000, 0, 0, 130, 32'h13050000);
    // RAM write of 2 bytes; miso activity must not reach fetched_value.
    run_req(1'b1, 18'h20010, 3'd2, 32'hAABBCCDD, 32'hFFFF0000, 0, 0, 98, 32'h0);
    // Single-byte read.
    run_req(1'b0, 18'h1ABCD, 3'd1, 32'h0, 32'h80FFFFFF, 0, 0, 82, 32'h00000080);
    // Three-byte read from the top RAM address.
    run_req(1'b0, 18'h3FFFF, 3'd3, 32'h0, 32'h112233FF, 0, 0, 114, 32'h00112233);
    // Handshake: start held 5 cycles past done, then an immediate re-request.
    run_req(1'b0, 18'h0F0F0, 3'd2, 32'h0, 32'hA55A0000, 5, 0, 98, 32'h0000A55A);
    run_req(1'b1, 18'h00000, 3'd4, 32'h12345678, 32'hFFFFFFFF, 0, 0, 130, 32'h0);
    // Zero-length request.
    run_req(1'b0, 18'h00040, 3'd0, 32'h0, 32'hFFFFFFFF, 0, 0, 1, 32'h0);
    // Oversized count clamps to 4.
    run_req(1'b0, 18'h20000, 3'd7, 32'h0, 32'h01020304, 0, 0, 130, 32'h01020304);
    // start_request dropped mid-transaction.
    run_req(1'b0, 18'h00200, 3'd1, 32'h0, 32'h5Cxxxxxx & 32'hFF000000, 0, 10, 82, 32'h0000005C);

    // Reset during the address phase.
    miso_word          = 32'hDEADBEEF;
    bus.is_write       = 1'b0;
    bus.target_address = 18'h00100;
    bus.num_bytes      = 3'd4;
    bus.start_request  = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start_request = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_cs1", 32'(bus.cs1), 32'd1);
    check("midrst_cs2", 32'(bus.cs2), 32'd1);
    check("midrst_sclk", 32'(bus.sclk), 32'd0);
    check("midrst_done", 32'(bus.request_done), 32'd0);
    check("midrst_fetched", bus.fetched_value, 32'h0);
    rst = 1'b0;
    $display("txn %0d: reset during address phase", txn + 1);
    txn++;
    // Normal read after the reset.
    run_req(1'b0, 18'h00100, 3'd4, 32'h0, 32'h13050000, 0, 0, 130, 32'h13050000);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
